// File: rtl/bus_reg_responder.sv
// ============================================================================
// Module   : bus_reg_responder
// Purpose  : Command-bus responder with ID/scratch/control/counter/status regs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_reg_responder #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(16'hA55A)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bus_cmd_valid,
   input  logic                  bus_op,
   input  logic [ADDR_WIDTH-1:0] bus_addr,
   input  logic [DATA_WIDTH-1:0] bus_wr_data,
   output logic [DATA_WIDTH-1:0] bus_rd_data,
   output logic                  irq
);

   localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(6);

   localparam logic [2:0] C_ID      = 3'd0;
   localparam logic [2:0] C_SCRATCH = 3'd1;
   localparam logic [2:0] C_CTRL    = 3'd2;
   localparam logic [2:0] C_CNT     = 3'd3;
   localparam logic [2:0] C_CMP     = 3'd4;
   localparam logic [2:0] C_STATUS  = 3'd5;
   localparam logic [2:0] C_ERRADDR = 3'd6;

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
   logic [DATA_WIDTH-1:0] cnt_q,     cnt_d;
   logic [DATA_WIDTH-1:0] cmp_q,     cmp_d;
   logic [DATA_WIDTH-1:0] erraddr_q, erraddr_d;
   logic                  cnt_en_q,  cnt_en_d;
   logic                  irq_en_q,  irq_en_d;
   logic                  hit_q,     hit_d;
   logic                  err_q,     err_d;

   logic                  w_wr;
   logic                  w_rd;
   logic                  w_mapped;
   logic [2:0]            w_sel;
   logic [DATA_WIDTH-1:0] w_rd_val;
   logic [DATA_WIDTH-1:0] w_ctrl_val;
   logic [DATA_WIDTH-1:0] w_status_val;

   assign w_wr     = bus_cmd_valid & bus_op;
   assign w_rd     = bus_cmd_valid & ~bus_op;
   assign w_mapped = (bus_addr <= C_LAST_ADDR);
   assign w_sel    = bus_addr[2:0];

   always_comb begin
      w_ctrl_val      = '0;
      w_ctrl_val[0]   = cnt_en_q;
      w_ctrl_val[2]   = irq_en_q;
      w_status_val    = '0;
      w_status_val[0] = hit_q;
      w_status_val[1] = err_q;
   end

   // Read mux sees only current register values, so reads observe pre-update state.
   always_comb begin
      w_rd_val = '0;
      if (w_mapped) begin
         case (w_sel)
            C_ID:      w_rd_val = ID_VALUE;
            C_SCRATCH: w_rd_val = scratch_q;
            C_CTRL:    w_rd_val = w_ctrl_val;
            C_CNT:     w_rd_val = cnt_q;
            C_CMP:     w_rd_val = cmp_q;
            C_STATUS:  w_rd_val = w_status_val;
            C_ERRADDR: w_rd_val = erraddr_q;
            default:   w_rd_val = '0;
         endcase
      end
   end

   always_comb begin
      rd_data_d = w_rd ? w_rd_val : rd_data_q;
      scratch_d = scratch_q;
      cmp_d     = cmp_q;
      cnt_en_d  = cnt_en_q;
      irq_en_d  = irq_en_q;
      erraddr_d = erraddr_q;
      cnt_d     = cnt_en_q ? cnt_q + 1'b1 : cnt_q;
      hit_d     = hit_q;
      err_d     = err_q;

      if (w_wr && w_mapped) begin
         case (w_sel)
            C_SCRATCH: scratch_d = bus_wr_data;
            C_CTRL: begin
               cnt_en_d = bus_wr_data[0];
               irq_en_d = bus_wr_data[2];
               if (bus_wr_data[1]) cnt_d = '0;
            end
            C_CMP: cmp_d = bus_wr_data;
            C_STATUS: begin
               if (bus_wr_data[0]) hit_d = 1'b0;
               if (bus_wr_data[1]) err_d = 1'b0;
            end
            default: ;
         endcase
      end

      // Set sources are applied after W1C so that a coincident set wins.
      if (cnt_en_q && (cnt_q == cmp_q)) hit_d = 1'b1;
      if (bus_cmd_valid && !w_mapped) begin
         err_d     = 1'b1;
         erraddr_d = DATA_WIDTH'(bus_addr);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         cmp_q     <= '1;
         erraddr_q <= '0;
         cnt_en_q  <= 1'b0;
         irq_en_q  <= 1'b0;
         hit_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         erraddr_q <= erraddr_d;
         cnt_en_q  <= cnt_en_d;
         irq_en_q  <= irq_en_d;
         hit_q     <= hit_d;
         err_q     <= err_d;
      end
   end

   assign bus_rd_data = rd_data_q;
   assign irq         = hit_q & irq_en_q;

endmodule

`default_nettype wire
